// File: rtl/fifo_core_if.sv
// Handshake and status bundle between a FIFO user (master) and fifo_core (slave).
interface fifo_core_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;
  logic [CntW-1:0]       count;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, almostfull, empty, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, almostfull, empty, almostempty, count
  );
endinterface

// File: rtl/fifo_core.sv
// Synchronous single-clock FIFO with registered read data, per-cycle write/overflow/underflow
// pulses and occupancy-decoded status flags.
module fifo_core #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic         clk,
  input logic         rst,
  fifo_core_if.slave  bus
);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, almostfull, empty, almostempty;
  logic wr_acc, rd_acc;

  // Status flags are pure decodes of occupancy, so they are mutually exclusive by construction.
  always_comb begin
    full        = (count_q == CntW'(FIFO_DEPTH));
    almostfull  = (count_q == CntW'(FIFO_DEPTH - 1));
    empty       = (count_q == '0);
    almostempty = (count_q == CntW'(1));
  end

  // Accept decisions and next-state for pointers, occupancy, read data and pulse flags.
  always_comb begin
    wr_acc      = bus.wr_en && !full;
    rd_acc      = bus.rd_en && !empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    wr_ack_d    = wr_acc;
    overflow_d  = bus.wr_en && full;
    underflow_d = bus.rd_en && empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    if (wr_acc) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + AddrW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is never reset; stale words are unreachable while count is zero.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out    = data_out_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full;
  assign bus.almostfull  = almostfull;
  assign bus.empty       = empty;
  assign bus.almostempty = almostempty;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_fifo_core.sv
// Scoreboard bench for fifo_core: a queue model predicts acceptance, flags and read order.
module tb_fifo_core;
  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_core_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) bus_if ();

  fifo_core #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".count"},       32'(bus_if.count),       32'(n));
    check({tag, ".full"},        32'(bus_if.full),        32'(n == int'(D)));
    check({tag, ".almostfull"},  32'(bus_if.almostfull),  32'(n == int'(D) - 1));
    check({tag, ".empty"},       32'(bus_if.empty),       32'(n == 0));
    check({tag, ".almostempty"}, 32'(bus_if.almostempty), 32'(n == 1));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".data_out"},  32'(bus_if.data_out),  32'h0);
    check({tag, ".wr_ack"},    32'(bus_if.wr_ack),    32'h0);
    check({tag, ".overflow"},  32'(bus_if.overflow),  32'h0);
    check({tag, ".underflow"}, 32'(bus_if.underflow), 32'h0);
    check({tag, ".count"},     32'(bus_if.count),     32'h0);
    check({tag, ".empty"},     32'(bus_if.empty),     32'h1);
    check({tag, ".full"},      32'(bus_if.full),      32'h0);
    check({tag, ".afull"},     32'(bus_if.almostfull), 32'h0);
    check({tag, ".aempty"},    32'(bus_if.almostempty), 32'h0);
  endtask

  // One clock of stimulus; the model decides what the DUT must accept.
  task automatic do_cycle(input logic wr, input logic rd, input logic [W-1:0] din);
    bit m_full, m_empty, wa, ra;
    @(negedge clk);
    bus_if.wr_en   = wr;
    bus_if.rd_en   = rd;
    bus_if.data_in = din;
    m_full  = (model_q.size() == int'(D));
    m_empty = (model_q.size() == 0);
    wa = wr && !m_full;
    ra = rd && !m_empty;
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(din);
    @(posedge clk);
    #1;
    check("wr_ack",    32'(bus_if.wr_ack),    32'(wa));
    check("overflow",  32'(bus_if.overflow),  32'(wr && m_full));
    check("underflow", 32'(bus_if.underflow), 32'(rd && m_empty));
    if (ra) last_out = exp_q.pop_front();
    check("data_out",  32'(bus_if.data_out),  32'(last_out));
    check_status("st");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    bus_if.data_in = '0;
    last_out       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill, then one write too many.
    for (int i = 1; i <= 8; i++) do_cycle(1'b1, 1'b0, W'(i));
    do_cycle(1'b1, 1'b0, 16'hFFFF);

    // Drain in order, then one read too many (data_out must hold 0x0008).
    for (int i = 0; i < 9; i++) do_cycle(1'b0, 1'b1, '0);
    check("drain_hold", 32'(bus_if.data_out), 32'h0008);

    // Simultaneous at empty: write only.
    do_cycle(1'b1, 1'b1, 16'hA5A5);
    do_cycle(1'b0, 1'b1, '0);
    check("empty_sim_read", 32'(bus_if.data_out), 32'hA5A5);

    // Simultaneous at full: read only, oldest entry appears.
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, W'(16'h0010 + i));
    do_cycle(1'b1, 1'b1, 16'hBEEF);
    check("full_sim_oldest", 32'(bus_if.data_out), 32'h0010);
    for (int i = 0; i < 7; i++) do_cycle(1'b0, 1'b1, '0);

    // Wrap: hold occupancy at 3 across many pointer wraps.
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, W'(16'h00F0 + i));
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'b1, W'(16'h0100 + i));
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, '0);
    check("wrap_last", 32'(bus_if.data_out), 32'h0113);

    // Asynchronous reset mid-cycle with traffic requested.
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, W'(16'h0200 + i));
    @(negedge clk);
    bus_if.wr_en   = 1'b1;
    bus_if.rd_en   = 1'b1;
    bus_if.data_in = 16'h5555;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async");
    @(posedge clk);
    #1;
    check_reset_state("held");
    @(negedge clk);
    rst          = 1'b0;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    model_q.delete();
    exp_q.delete();
    last_out = '0;
    do_cycle(1'b1, 1'b0, 16'h1234);
    do_cycle(1'b0, 1'b1, '0);
    check("post_reset_read", 32'(bus_if.data_out), 32'h1234);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
    end
    do_cycle(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
